// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller and decode.
// Holds the controller state type, default stall counts and opcode constants.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } ctrl_state_e;

    localparam int LOAD_USE_STALLS_DEF        = 1;
    localparam int ALU_BRANCH_STALLS_DEF      = 1;
    localparam int LOAD_BRANCH_EX_STALLS_DEF  = 2;
    localparam int LOAD_BRANCH_MEM_STALLS_DEF = 1;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // The counter must hold any stall count up to and including the largest one.
    function automatic int cnt_width(input int max_stalls);
        int w;
        w = $clog2(max_stalls + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_hazard_match.sv
// Combinational hazard matcher: compares ID sources against EX/MEM destinations
// and returns how many stall cycles the ID instruction needs.
module hazard_match
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W                  = 5,
    parameter int CNT_W                  = 2,
    parameter int LOAD_USE_STALLS        = LOAD_USE_STALLS_DEF,
    parameter int ALU_BRANCH_STALLS      = ALU_BRANCH_STALLS_DEF,
    parameter int LOAD_BRANCH_EX_STALLS  = LOAD_BRANCH_EX_STALLS_DEF,
    parameter int LOAD_BRANCH_MEM_STALLS = LOAD_BRANCH_MEM_STALLS_DEF
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rt,
    input  logic             branch,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    output logic [CNT_W-1:0] stalls_needed
);

    logic ex_match;
    logic mem_match;

    // Register $0 is hardwired, so a write to it never produces a hazard.
    always_comb begin
        ex_match  = ex_reg_write && (ex_dst != '0) &&
                    ((ex_dst == rs) || (uses_rt && (ex_dst == rt)));
        mem_match = mem_reg_write && (mem_dst != '0) &&
                    ((mem_dst == rs) || (uses_rt && (mem_dst == rt)));

        stalls_needed = '0;
        if (branch) begin
            if (ex_match && ex_mem_read) begin
                stalls_needed = CNT_W'(LOAD_BRANCH_EX_STALLS);
            end else if (ex_match) begin
                stalls_needed = CNT_W'(ALU_BRANCH_STALLS);
            end else if (mem_match && mem_mem_read) begin
                stalls_needed = CNT_W'(LOAD_BRANCH_MEM_STALLS);
            end
        end else if (ex_match && ex_mem_read) begin
            stalls_needed = CNT_W'(LOAD_USE_STALLS);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Counted stall/flush/freeze sequencer for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W                  = 5,
    parameter int LOAD_USE_STALLS        = LOAD_USE_STALLS_DEF,
    parameter int ALU_BRANCH_STALLS      = ALU_BRANCH_STALLS_DEF,
    parameter int LOAD_BRANCH_EX_STALLS  = LOAD_BRANCH_EX_STALLS_DEF,
    parameter int LOAD_BRANCH_MEM_STALLS = LOAD_BRANCH_MEM_STALLS_DEF,
    parameter int PERF_W                 = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [REG_W-1:0]  IF_IDRs,
    input  logic [REG_W-1:0]  IF_IDRt,
    input  logic              IF_IDUsesRt,
    input  logic              IF_IDBranch,
    input  logic              BranchTaken,
    input  logic [REG_W-1:0]  ID_EXDst,
    input  logic              ID_EXRegWrite,
    input  logic              ID_EXMemRead,
    input  logic [REG_W-1:0]  EX_MEMDst,
    input  logic              EX_MEMRegWrite,
    input  logic              EX_MEMMemRead,
    input  logic              MemBusy,
    output logic              PCWrite,
    output logic              IF_IDWrite,
    output logic              IF_IDFlush,
    output logic              ID_EXStall,
    output logic              PipeHold,
    output logic [PERF_W-1:0] StallCycles,
    output logic [PERF_W-1:0] FlushCount
);

    localparam int MAX_STALLS = max4(LOAD_USE_STALLS, ALU_BRANCH_STALLS,
                                     LOAD_BRANCH_EX_STALLS, LOAD_BRANCH_MEM_STALLS);
    localparam int CNT_W = cnt_width(MAX_STALLS);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stalls_needed;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_stall;
    logic pipe_hold;

    hazard_match #(
        .REG_W                  (REG_W),
        .CNT_W                  (CNT_W),
        .LOAD_USE_STALLS        (LOAD_USE_STALLS),
        .ALU_BRANCH_STALLS      (ALU_BRANCH_STALLS),
        .LOAD_BRANCH_EX_STALLS  (LOAD_BRANCH_EX_STALLS),
        .LOAD_BRANCH_MEM_STALLS (LOAD_BRANCH_MEM_STALLS)
    ) u_hazard_match (
        .rs            (IF_IDRs),
        .rt            (IF_IDRt),
        .uses_rt       (IF_IDUsesRt),
        .branch        (IF_IDBranch),
        .ex_dst        (ID_EXDst),
        .ex_reg_write  (ID_EXRegWrite),
        .ex_mem_read   (ID_EXMemRead),
        .mem_dst       (EX_MEMDst),
        .mem_reg_write (EX_MEMRegWrite),
        .mem_mem_read  (EX_MEMMemRead),
        .stalls_needed (stalls_needed)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MemBusy freezes everything (a pending flush simply reappears once it drops),
    // then the counted stall, then the taken-branch flush.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        pipe_hold   = 1'b0;

        if (MemBusy) begin
            pipe_hold   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (state_q == STALL) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_stall = 1'b1;
            cnt_d       = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = RUN;
            end
        end else if (stalls_needed != '0) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_stall = 1'b1;
            cnt_d       = stalls_needed - CNT_W'(1);
            state_d     = (stalls_needed > CNT_W'(1)) ? STALL : RUN;
        end else if (IF_IDBranch && BranchTaken) begin
            if_id_flush = 1'b1;
        end
    end

    // Reset forces the outputs directly so a stall is abandoned without waiting for a clock.
    assign PCWrite    = Reset_n & pc_write;
    assign IF_IDWrite = Reset_n & if_id_write;
    assign IF_IDFlush = Reset_n & if_id_flush;
    assign ID_EXStall = ~Reset_n | id_ex_stall;
    assign PipeHold   = Reset_n & pipe_hold;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!MemBusy && id_ex_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
        if (!MemBusy && if_id_flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushCount  = flush_count_q;
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// traffic checked every cycle against a cycle-count model of the stall rules.
module tb_pipeline_stall_controller;

    localparam int REG_W  = 5;
    localparam int PERF_W = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    // Control vector order: {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXStall, PipeHold}
    localparam logic [4:0] V_RUN   = 5'b11000;
    localparam logic [4:0] V_STALL = 5'b00010;
    localparam logic [4:0] V_FLUSH = 5'b11100;
    localparam logic [4:0] V_HOLD  = 5'b00001;
    localparam logic [4:0] V_RESET = 5'b00010;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic [REG_W-1:0]  IF_IDRs = '0, IF_IDRt = '0;
    logic              IF_IDUsesRt = 1'b0, IF_IDBranch = 1'b0, BranchTaken = 1'b0;
    logic [REG_W-1:0]  ID_EXDst = '0;
    logic              ID_EXRegWrite = 1'b0, ID_EXMemRead = 1'b0;
    logic [REG_W-1:0]  EX_MEMDst = '0;
    logic              EX_MEMRegWrite = 1'b0, EX_MEMMemRead = 1'b0;
    logic              MemBusy = 1'b0;
    logic              PCWrite, IF_IDWrite, IF_IDFlush, ID_EXStall, PipeHold;
    logic [PERF_W-1:0] StallCycles, FlushCount;

    int testsRun = 0;
    int testsFailed = 0;

    int mLeft = 0;
    longint mStalls = 0;
    longint mFlushes = 0;

    pipeline_stall_controller dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .IF_IDRs        (IF_IDRs),
        .IF_IDRt        (IF_IDRt),
        .IF_IDUsesRt    (IF_IDUsesRt),
        .IF_IDBranch    (IF_IDBranch),
        .BranchTaken    (BranchTaken),
        .ID_EXDst       (ID_EXDst),
        .ID_EXRegWrite  (ID_EXRegWrite),
        .ID_EXMemRead   (ID_EXMemRead),
        .EX_MEMDst      (EX_MEMDst),
        .EX_MEMRegWrite (EX_MEMRegWrite),
        .EX_MEMMemRead  (EX_MEMMemRead),
        .MemBusy        (MemBusy),
        .PCWrite        (PCWrite),
        .IF_IDWrite     (IF_IDWrite),
        .IF_IDFlush     (IF_IDFlush),
        .ID_EXStall     (ID_EXStall),
        .PipeHold       (PipeHold),
        .StallCycles    (StallCycles),
        .FlushCount     (FlushCount)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [4:0] ctrlVec();
        return {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXStall, PipeHold};
    endfunction

    // Stall requirement straight from the hazard table with default parameters.
    function automatic int needStalls();
        bit exHit, memHit;
        exHit = ID_EXRegWrite && ID_EXDst != 0 &&
                (ID_EXDst == IF_IDRs || (IF_IDUsesRt && ID_EXDst == IF_IDRt));
        memHit = EX_MEMRegWrite && EX_MEMDst != 0 &&
                 (EX_MEMDst == IF_IDRs || (IF_IDUsesRt && EX_MEMDst == IF_IDRt));
        if (IF_IDBranch) begin
            if (exHit && ID_EXMemRead) return 2;
            if (exHit) return 1;
            if (memHit && EX_MEMMemRead) return 1;
            return 0;
        end
        if (exHit && ID_EXMemRead) return 1;
        return 0;
    endfunction

    // Compare process: outputs and counters every cycle, model advanced afterwards.
    always @(negedge Clk) begin
        logic [4:0] expV;
        int n;
        if (!Reset_n) begin
            mLeft = 0;
            mStalls = 0;
            mFlushes = 0;
            expV = V_RESET;
        end else if (MemBusy) begin
            expV = V_HOLD;
        end else if (mLeft > 0) begin
            expV = V_STALL;
            mLeft--;
        end else begin
            n = needStalls();
            if (n > 0) begin
                expV = V_STALL;
                mLeft = n - 1;
            end else if (IF_IDBranch && BranchTaken) begin
                expV = V_FLUSH;
            end else begin
                expV = V_RUN;
            end
        end
        checkOutput("ctrl", 64'(ctrlVec()), 64'(expV));
        checkOutput("StallCycles", 64'(StallCycles), PERF_EN ? 64'(mStalls) : 64'd0);
        checkOutput("FlushCount", 64'(FlushCount), PERF_EN ? 64'(mFlushes) : 64'd0);
        if (Reset_n && !MemBusy) begin
            if (expV[1]) mStalls++;
            if (expV[2]) mFlushes++;
        end
    end

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                 input logic br, input logic taken,
                                 input logic [4:0] exDst, input logic exW, input logic exR,
                                 input logic [4:0] memDst, input logic memW, input logic memR,
                                 input logic busy);
        @(posedge Clk);
        #1;
        IF_IDRs = rs; IF_IDRt = rt; IF_IDUsesRt = usesRt;
        IF_IDBranch = br; BranchTaken = taken;
        ID_EXDst = exDst; ID_EXRegWrite = exW; ID_EXMemRead = exR;
        EX_MEMDst = memDst; EX_MEMRegWrite = memW; EX_MEMMemRead = memR;
        MemBusy = busy;
    endtask

    task automatic checkCtrl(input string name, input logic [4:0] expV);
        #2;
        checkOutput(name, 64'(ctrlVec()), 64'(expV));
    endtask

    initial begin
        #2;
        checkOutput("reset_ctrl", 64'(ctrlVec()), 64'(V_RESET));
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        checkCtrl("idle_after_reset", V_RUN);

        // Load-use: lw $5 in EX, add reading $5 in ID
        applyStimulus(5, 7, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        checkCtrl("load_use_stall", V_STALL);
        applyStimulus(5, 7, 1, 0, 0, 0, 0, 0, 5, 1, 1, 0);
        checkCtrl("load_use_resume", V_RUN);
        checkOutput("load_use_count", 64'(StallCycles), PERF_EN ? 64'd1 : 64'd0);

        // Load then branch: two stalls, BranchTaken ignored throughout
        applyStimulus(8, 0, 0, 1, 1, 8, 1, 1, 0, 0, 0, 0);
        checkCtrl("ld_br_stall1", V_STALL);
        applyStimulus(8, 0, 0, 1, 1, 8, 1, 1, 0, 0, 0, 0);
        checkCtrl("ld_br_stall2", V_STALL);
        applyStimulus(8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCtrl("ld_br_resume", V_RUN);
        checkOutput("ld_br_no_flush", 64'(FlushCount), 64'd0);

        // $0 destination never hazards
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0);
        checkCtrl("zero_reg", V_RUN);

        // Taken branch without hazard: single-cycle flush
        applyStimulus(3, 4, 1, 1, 1, 9, 1, 0, 10, 1, 1, 0);
        checkCtrl("taken_flush", V_FLUSH);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCtrl("flush_one_cycle", V_RUN);
        checkOutput("flush_count", 64'(FlushCount), PERF_EN ? 64'd1 : 64'd0);

        // Flush deferred while memory is busy
        applyStimulus(3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        checkCtrl("flush_deferred", V_HOLD);
        applyStimulus(3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkCtrl("flush_after_busy", V_FLUSH);

        // MemBusy for three cycles in STALL with one stall cycle remaining
        applyStimulus(6, 0, 0, 1, 0, 6, 1, 1, 0, 0, 0, 0);
        checkCtrl("busy_stall_start", V_STALL);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6, 0, 0, 1, 0, 6, 1, 1, 0, 0, 0, 1);
            checkCtrl("busy_hold", V_HOLD);
        end
        applyStimulus(6, 0, 0, 1, 1, 6, 1, 1, 0, 0, 0, 0);
        checkCtrl("busy_last_stall", V_STALL);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCtrl("busy_resume", V_RUN);

        // Asynchronous reset in the middle of a stall
        applyStimulus(8, 0, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0);
        checkCtrl("mid_stall_start", V_STALL);
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1 checkOutput("async_reset_ctrl", 64'(ctrlVec()), 64'(V_RESET));
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        IF_IDRs = '0; IF_IDBranch = 1'b0; ID_EXDst = '0; ID_EXRegWrite = 1'b0; ID_EXMemRead = 1'b0;
        checkCtrl("after_reset_run", V_RUN);

        // Random traffic, checked by the compare process
        for (int i = 0; i < 600; i++) begin
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) < 2));
        end

        @(posedge Clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Sequencing controller for the 5-stage MIPS pipeline; owns PC, IF/ID and ID/EX write/flush/bubble control.
- Detects load-use and branch-operand hazards, then holds a stall for a counted number of cycles.
- Issues IF/ID flush on taken branches and freezes the whole pipeline while data memory is busy.
- Sits between decode and the pipeline registers; replaces ad hoc combinational stall logic with a counted FSM.

Parameters:
- REG_W, 5, register-address width.
- LOAD_USE_STALLS, 1, stall cycles for a non-branch consumer of a load in EX.
- ALU_BRANCH_STALLS, 1, stall cycles for a branch depending on an ALU result in EX.
- LOAD_BRANCH_EX_STALLS, 2, stall cycles for a branch depending on a load in EX.
- LOAD_BRANCH_MEM_STALLS, 1, stall cycles for a branch depending on a load in MEM.
- PERF_W, 32, performance-counter width.

Ports:
- Clk  in  1  clock.
- Reset_n  in  1  asynchronous active-low reset.
- IF_IDRs / IF_IDRt  in  REG_W each  source registers of the ID instruction.
- IF_IDUsesRt  in  1  ID instruction reads Rt as a source.
- IF_IDBranch  in  1  ID instruction is a branch (beq/bne class).
- BranchTaken  in  1  ID-stage compare result; valid only when no hazard is flagged.
- ID_EXDst  in  REG_W  destination register of the EX instruction.
- ID_EXRegWrite / ID_EXMemRead  in  1 each  EX instruction control bits.
- EX_MEMDst  in  REG_W  destination register of the MEM instruction.
- EX_MEMRegWrite / EX_MEMMemRead  in  1 each  MEM instruction control bits.
- MemBusy  in  1  data memory not ready.
- PCWrite  out  1  PC may update.
- IF_IDWrite  out  1  IF/ID may load.
- IF_IDFlush  out  1  IF/ID cleared to NOP at the next edge.
- ID_EXStall  out  1  ID/EX loads a bubble.
- PipeHold  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- StallCycles  out  PERF_W  counted stall cycles.
- FlushCount  out  PERF_W  counted flushes.

Behaviour:
- Match rule: EX match = ID_EXRegWrite & ID_EXDst != 0 & (ID_EXDst == IF_IDRs | (IF_IDUsesRt & ID_EXDst == IF_IDRt)). MEM match uses the same rule with the EX_MEM signals. Register $0 never creates a hazard.
- Required stalls N:
  - Branch: load EX match gives LOAD_BRANCH_EX_STALLS; else ALU EX match gives ALU_BRANCH_STALLS; else load MEM match gives LOAD_BRANCH_MEM_STALLS.
  - Non-branch: load EX match gives LOAD_USE_STALLS.
  - Otherwise N = 0.
- States:
  - RUN: if N > 0, assert the stall outputs this cycle (Mealy), load Cnt = N-1, go to STALL if Cnt > 0 else stay in RUN.
  - RUN with N = 0: if IF_IDBranch & BranchTaken, IF_IDFlush = 1 for one cycle with PCWrite = 1 so the target loads.
  - STALL: inputs are ignored. Stall outputs are asserted and Cnt decrements; when Cnt = 1 the next state is RUN, where hazards are re-evaluated.
- Stall outputs: PCWrite = 0, IF_IDWrite = 0, ID_EXStall = 1, IF_IDFlush = 0.
- Priority: MemBusy > hazard stall > flush.
  - MemBusy = 1 in any state: PipeHold = 1, PCWrite = 0, IF_IDWrite = 0, ID_EXStall = 0, IF_IDFlush = 0.
  - During MemBusy, state and Cnt are frozen, and the flush is deferred until MemBusy drops.
- Default outputs in RUN with no event: PCWrite = 1, IF_IDWrite = 1, others 0.
- Reset (async): state = RUN, Cnt = 0, counters = 0. Outputs during reset: PCWrite = 0, IF_IDWrite = 0, IF_IDFlush = 0, ID_EXStall = 1, PipeHold = 0.
- Reset mid-STALL aborts the stall immediately.
- Cnt width: clog2 of the maximum stall parameter + 1.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: StallCycles increments on every cycle with ID_EXStall = 1 and FlushCount on every IF_IDFlush = 1. Both saturate at all-ones and do not count while MemBusy = 1.
- Not defined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state typedef {RUN, STALL};
  - stall-count constants;
  - opcode constants LW/LH/LB/BEQ/BNE reused by decode.
- One sub-module, hazard_match (combinational match/N computation); it is reusable by the forwarding unit.

Test Plan:
- Load-use: lw $5 in EX (ID_EXMemRead = 1, ID_EXDst = 5), add in ID with Rs = 5 → one cycle of PCWrite = 0 / ID_EXStall = 1, then normal flow; StallCycles = 1.
- Load then branch: lw $8 in EX, beq Rs = 8 → 2 consecutive stall cycles, FSM RUN → STALL → RUN; BranchTaken ignored during both.
- $0 destination: ID_EXRegWrite = 1, ID_EXDst = 0, Rs = 0 → no stall.
- Taken branch: beq with no hazard, BranchTaken = 1 → IF_IDFlush = 1 for exactly one cycle, PCWrite = 1, FlushCount = 1.
- MemBusy: assert MemBusy for 3 cycles during STALL with Cnt = 1 → PipeHold = 1 for 3 cycles, Cnt held, then 1 remaining stall cycle.
- Reset: deassert Reset_n asynchronously mid-STALL → outputs take their reset values immediately; after release, state = RUN with PCWrite = 1.
